// File: rtl/demux_rr_scheduler.sv
// Round-robin owner of the 1-to-4 DEMUX LED path.
// Timed grant slots with a one-cycle gap on each hand-over.
module demux_rr_scheduler #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SLOT_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] req,
  output logic [1:0] select,
  output logic       demux_in,
  output logic [3:0] grant,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SLOT_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [SW-1:0] slot, slot_n;
  logic [1:0]    ptr, ptr_n;
  logic [1:0]    select_n;
  logic          demux_in_n;
  logic [3:0]    grant_n;
  logic          busy_n;
  logic [1:0]    nxt, idx;
  logic          found;
  logic          tick, start, hand_over;

  always_comb begin
    nxt   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign tick      = presc == PW'(TICK_DIV - 1);
  assign start     = enable && (req != 4'b0);
  // select still names the owner while in GRANT
  assign hand_over = (tick && slot == SW'(SLOT_TICKS - 1))
                   || !req[select] || !enable;

  always_comb begin
    state_n    = state;
    presc_n    = presc;
    slot_n     = slot;
    ptr_n      = ptr;
    select_n   = select;
    demux_in_n = demux_in;
    grant_n    = grant;
    busy_n     = busy;
    unique case (state)
      IDLE, GAP: begin
        if (start) begin
          state_n    = GRANT;
          presc_n    = '0;
          slot_n     = '0;
          ptr_n      = nxt;
          select_n   = nxt;
          demux_in_n = 1'b1;
          grant_n    = 4'b0001 << nxt;
          busy_n     = 1'b1;
        end else begin
          state_n    = IDLE;
          demux_in_n = 1'b0;
          grant_n    = 4'b0;
          busy_n     = 1'b0;
        end
      end
      GRANT: begin
        if (hand_over) begin
          state_n    = GAP;
          demux_in_n = 1'b0;
          grant_n    = 4'b0;
          busy_n     = 1'b1;
        end else if (tick) begin
          presc_n = '0;
          slot_n  = slot + 1'b1;
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      default: begin
        state_n    = IDLE;
        demux_in_n = 1'b0;
        grant_n    = 4'b0;
        busy_n     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      slot     <= '0;
      ptr      <= 2'd3;
      select   <= 2'd0;
      demux_in <= 1'b0;
      grant    <= 4'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      slot     <= slot_n;
      ptr      <= ptr_n;
      select   <= select_n;
      demux_in <= demux_in_n;
      grant    <= grant_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Bench for demux_rr_scheduler: directed stimulus, grant bursts
// checked by a monitor against a queue of expected bursts.
module tb_demux_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] req;
  logic [1:0] select;
  logic       demux_in;
  logic [3:0] grant;
  logic       busy;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [3:0] g;
    int         len;
  } exp_t;

  exp_t q[$];

  demux_rr_scheduler #(
    .TICK_DIV  (4),
    .SLOT_TICKS(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .req     (req),
    .select  (select),
    .demux_in(demux_in),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk_idle(input string name);
    @(negedge clk);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_grant"}, 32'(grant), 32'd0);
    chk({name, "_din"}, 32'(demux_in), 32'd0);
  endtask

  task automatic settle_and_reset();
    repeat (3) @(posedge clk);
    chk_idle("settle");
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // monitor: one expected entry per grant burst
  initial begin : monitor
    logic [3:0] cur_g;
    int         cur_len;
    bit         in_burst;
    bit         bad;
    exp_t       e;
    cur_g    = 4'b0;
    cur_len  = 0;
    in_burst = 1'b0;
    bad      = 1'b0;
    forever begin
      @(negedge clk);
      if (!$isunknown(grant) && grant != 4'b0) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          cur_g    = grant;
          cur_len  = 0;
          bad      = 1'b0;
        end
        cur_len++;
        if (grant !== cur_g || demux_in !== 1'b1 || busy !== 1'b1 ||
            (4'b0001 << select) !== grant)
          bad = 1'b1;
      end else if (in_burst) begin
        in_burst = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected_grant", 32'(cur_g), 32'd0);
        end else begin
          e = q.pop_front();
          chk("burst_grant", 32'(cur_g), 32'(e.g));
          if (e.len > 0)
            chk("burst_len", 32'(cur_len), 32'(e.len));
          chk("burst_hold", 32'(bad), 32'd0);
          if (rst_n) begin
            chk("gap_select", 32'(select), 32'(oh2i(e.g)));
            chk("gap_din", 32'(demux_in), 32'd0);
            chk("gap_busy", 32'(busy), 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: run exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1);
  end

  initial begin : stim
    rst_n  = 1'b0;
    req    = 4'hF;
    enable = 1'b1;

    // reset dominates requests
    repeat (2) begin
      @(negedge clk);
      chk("rst_select", 32'(select), 32'd0);
      chk("rst_din", 32'(demux_in), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single persistent requester
    req = 4'b0100;
    q.push_back('{4'b0100, 8});
    q.push_back('{4'b0100, 8});
    repeat (17) @(posedge clk);
    #1 req = 4'b0;
    settle_and_reset();

    // full round robin
    req = 4'hF;
    q.push_back('{4'b0001, 8});
    q.push_back('{4'b0010, 8});
    q.push_back('{4'b0100, 8});
    q.push_back('{4'b1000, 8});
    q.push_back('{4'b0001, 8});
    repeat (44) @(posedge clk);
    #1 req = 4'b0;
    settle_and_reset();

    // early release of owner 0
    req = 4'b0011;
    q.push_back('{4'b0001, 3});
    q.push_back('{4'b0010, 8});
    repeat (3) @(posedge clk);
    #1 req = 4'b0010;
    repeat (9) @(posedge clk);
    #1 req = 4'b0;
    settle_and_reset();

    // enable drop mid-slot
    req = 4'b0001;
    q.push_back('{4'b0001, 4});
    repeat (4) @(posedge clk);
    #1 enable = 1'b0;
    repeat (2) @(posedge clk);
    repeat (3) chk_idle("en_low");
    @(posedge clk);
    #1 begin
      req    = 4'b0;
      enable = 1'b1;
    end
    settle_and_reset();

    // reset during owner 3's slot
    req = 4'b1000;
    q.push_back('{4'b1000, 3});
    q.push_back('{4'b0001, 8});
    repeat (3) @(posedge clk);
    #1 begin
      rst_n = 1'b0;
      req   = 4'b1001;
    end
    @(posedge clk);
    @(negedge clk);
    chk("mrst_select", 32'(select), 32'd0);
    chk("mrst_din", 32'(demux_in), 32'd0);
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 req = 4'b0;

    repeat (4) @(posedge clk);
    chk_idle("final");
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
